shared_mem_arbiter: RTL and testbench

- Shares one single-port data memory between NUM_CORES core memory stages.
- Each core presents the shared-memory request from its memory stage (mask, address, write data) plus a request/write flag.
- Round-robin arbitration; one access in flight at a time.
- Reads are returned to the owning core after the memory's fixed latency; writes complete at grant.

---
 rtl/shared_mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
//
// Lets NUM_CORES core memory stages share one single-port data memory.
// Requests are arbitrated round-robin, and only one access is in flight at a
// time. A write completes when it is granted. A read is returned to its owner
// MEM_LAT cycles after the memory strobe, plus one cycle to register the data.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   core_req       per-core request, held until core_gnt (write) / core_rvalid (read)
//   core_we        per-core write flag (1 = write, 0 = read)
//   core_mask      per-core byte-enable mask, core i at [4i+3:4i]
//   core_addr      per-core byte address, core i at [32i+31:32i]
//   core_wdata     per-core write data, same packing as core_addr
//   core_gnt       one-hot pulse: the owner's request was issued to memory
//   core_rvalid    one-hot pulse: core_rdata carries the owner's read data
//   core_rdata     registered read data, shared by all cores
//   mem_en/we/mask/addr/wdata  memory command, all zero when mem_en is low
//   mem_rdata      memory read data, valid MEM_LAT cycles after mem_en
//   busy           high whenever an access is being arbitrated out or is in flight
// -----------------------------------------------------------------------------
module shared_mem_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int MEM_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    core_req,
  input  logic [NUM_CORES-1:0]    core_we,
  input  logic [NUM_CORES*4-1:0]  core_mask,
  input  logic [NUM_CORES*32-1:0] core_addr,
  input  logic [NUM_CORES*32-1:0] core_wdata,
  output logic [NUM_CORES-1:0]    core_gnt,
  output logic [NUM_CORES-1:0]    core_rvalid,
  output logic [31:0]             core_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [3:0]              mem_mask,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  output logic                    busy
);

  localparam int OW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            we_q, we_d;
  logic [3:0]      mask_q, mask_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;

  // Round-robin winner: first requester found scanning upward from rr_ptr.
  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic            sel_we;
  logic [3:0]      sel_mask;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;

  // NOTE: every signal assigned in an always_comb gets a default value first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    int      idx;
    logic [OW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      cand = OW'(idx);
      if (!win_found && core_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_mask  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (win_idx == OW'(i)) begin
        sel_we    = core_we[i];
        sel_mask  = core_mask[4*i +: 4];
        sel_addr  = core_addr[32*i +: 32];
        sel_wdata = core_wdata[32*i +: 32];
      end
    end
  end

  // Next-state and output logic. Outputs depend only on registered state, so
  // nothing on the core or memory side sees a combinational path from inputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    core_gnt    = '0;
    core_rvalid = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_mask    = '0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        // Payload is captured here once; later changes on the core side
        // cannot disturb the access in flight.
        if (win_found) begin
          owner_d = win_idx;
          we_d    = sel_we;
          mask_d  = sel_mask;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        mem_en            = 1'b1;
        mem_we            = we_q;
        mem_mask          = mask_q;
        mem_addr          = addr_q;
        mem_wdata         = wdata_q;
        core_gnt[owner_q] = 1'b1;
        rr_ptr_d          = (owner_q == OW'(NUM_CORES - 1)) ? '0 : owner_q + OW'(1);
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CW'(MEM_LAT);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // The counter reaches 1 in the cycle the memory data is valid.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        core_rvalid[owner_q] = 1'b1;
        state_d              = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      mask_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  assign core_rdata = rdata_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arbiter
//
// Cores are driven on the falling edge. A transaction-level model turns each
// arbitration slot into expected events (grant cycle with memory command,
// read-return cycle with data) and queues them. A monitor, running 1 time unit
// after every rising edge, pops and compares whenever an event is due and
// otherwise requires a quiet bus. A small behavioural memory answers mem_en
// reads exactly MEM_LAT cycles later and returns random data at all other times.
// -----------------------------------------------------------------------------
module tb_shared_mem_arbiter;

  localparam int NUM_CORES = 2;
  localparam int MEM_LAT   = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CORES-1:0]    req_r;
  logic [NUM_CORES-1:0]    we_r;
  logic [3:0]              mask_r  [NUM_CORES];
  logic [31:0]             addr_r  [NUM_CORES];
  logic [31:0]             wdata_r [NUM_CORES];
  logic [NUM_CORES*4-1:0]  core_mask;
  logic [NUM_CORES*32-1:0] core_addr;
  logic [NUM_CORES*32-1:0] core_wdata;
  logic [NUM_CORES-1:0]    core_gnt;
  logic [NUM_CORES-1:0]    core_rvalid;
  logic [31:0]             core_rdata;
  logic                    mem_en;
  logic                    mem_we;
  logic [3:0]              mem_mask;
  logic [31:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic [31:0]             mem_rdata;
  logic                    busy;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      core_mask[4*i +: 4]   = mask_r[i];
      core_addr[32*i +: 32]  = addr_r[i];
      core_wdata[32*i +: 32] = wdata_r[i];
    end
  end

  shared_mem_arbiter #(
    .NUM_CORES(NUM_CORES),
    .MEM_LAT  (MEM_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (req_r),
    .core_we    (we_r),
    .core_mask  (core_mask),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_mask   (mem_mask),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    int          cyc;
    bit          is_rvalid;
    int          core;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] env_mem [logic [31:0]];
  int          rr          = 0;
  int          model_free  = 0;
  int          model_owner = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] env_read(logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : 32'h0;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory behaviour seen by the arbiter
  // ---------------------------------------------------------------------------
  bit          pend = 1'b0;
  int          pend_due = 0;
  logic [31:0] pend_data = '0;

  always @(negedge clk) begin
    if (pend && cyc == pend_due) begin
      mem_rdata = pend_data;
      pend      = 1'b0;
    end else begin
      mem_rdata = $urandom;
    end
    if (mem_en && !mem_we) begin
      pend      = 1'b1;
      pend_due  = cyc + MEM_LAT;
      pend_data = env_read(mem_addr);
    end
    if (mem_en && mem_we) env_mem[mem_addr] = merge(env_read(mem_addr), mem_wdata, mem_mask);
  end

  // ---------------------------------------------------------------------------
  // Reference model: one arbitration slot evaluated with the requests the DUT
  // samples at the end of cycle k.
  // ---------------------------------------------------------------------------
  task automatic model_arb(int k);
    if (!rst_n) begin
      exp_q.delete();
      rr          = 0;
      model_free  = k + 1;
      model_owner = -1;
      return;
    end
    if (k < model_free) return;
    for (int j = 0; j < NUM_CORES; j++) begin
      int i;
      i = (rr + j) % NUM_CORES;
      if (req_r[i]) begin
        exp_q.push_back('{k + 1, 1'b0, i, we_r[i], mask_r[i], addr_r[i], wdata_r[i]});
        if (we_r[i]) begin
          ref_mem[addr_r[i]] = merge(ref_read(addr_r[i]), wdata_r[i], mask_r[i]);
          model_free = k + 2;
        end else begin
          exp_q.push_back('{k + 2 + MEM_LAT, 1'b1, i, 1'b0, 4'h0, addr_r[i], ref_read(addr_r[i])});
          model_free = k + 3 + MEM_LAT;
        end
        rr          = (i + 1) % NUM_CORES;
        model_owner = i;
        return;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always begin
    ev_t e;
    int  p;
    @(posedge clk);
    #1;
    p = cyc;
    check("busy", busy, p < model_free);
    while (exp_q.size() > 0 && exp_q[0].cyc < p) begin
      check("overdue_event_cycle", p, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == p) begin
      e = exp_q.pop_front();
      if (!e.is_rvalid) begin
        check("core_gnt", core_gnt, 64'd1 << e.core);
        check("core_rvalid_at_gnt", core_rvalid, 0);
        check("mem_en", mem_en, 1);
        check("mem_we", mem_we, e.we);
        check("mem_mask", mem_mask, e.mask);
        check("mem_addr", mem_addr, e.addr);
        check("mem_wdata", mem_wdata, e.data);
      end else begin
        check("core_rvalid", core_rvalid, 64'd1 << e.core);
        check("core_gnt_at_rvalid", core_gnt, 0);
        check("mem_en_at_rvalid", mem_en, 0);
        check("core_rdata", core_rdata, e.data);
      end
    end else begin
      check("quiet_gnt", core_gnt, 0);
      check("quiet_rvalid", core_rvalid, 0);
      check("quiet_mem_en", mem_en, 0);
    end
    if (!mem_en) begin
      check("idle_mem_ctl", {mem_we, mem_mask}, 0);
      check("idle_mem_addr", mem_addr, 0);
      check("idle_mem_wdata", mem_wdata, 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_req(int i, logic we, logic [3:0] m, logic [31:0] a, logic [31:0] d);
    req_r[i]   = 1'b1;
    we_r[i]    = we;
    mask_r[i]  = m;
    addr_r[i]  = a;
    wdata_r[i] = d;
  endtask

  // Close the current cycle, then release requests that were served.
  task automatic cycle_end();
    model_arb(cyc);
    @(negedge clk);
    for (int i = 0; i < NUM_CORES; i++)
      if ((core_gnt[i] && we_r[i]) || core_rvalid[i]) req_r[i] = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (!(req_r == '0 && exp_q.size() == 0 && cyc >= model_free) && n < budget) begin
      cycle_end();
      n++;
    end
    if (n >= budget) check("drain_timeout_cycles", n, 0);
  endtask

  task automatic reset_outputs_zero();
    check("rst_core_gnt", core_gnt, 0);
    check("rst_core_rvalid", core_rvalid, 0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_ctl", {mem_we, mem_mask}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h1000 + ($urandom_range(0, 7) << 2);
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    req_r = '0;
    we_r  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      mask_r[i]  = '0;
      addr_r[i]  = '0;
      wdata_r[i] = '0;
    end
    ref_mem[32'h200] = 32'hCAFEF00D;
    env_mem[32'h200] = 32'hCAFEF00D;

    repeat (3) cycle_end();
    reset_outputs_zero();
    rst_n = 1'b1;

    // Single write, single reads, masked writes.
    set_req(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF); wait_idle(50);
    set_req(1, 1'b0, 4'hF, 32'h200, 32'h0);        wait_idle(50);
    set_req(0, 1'b0, 4'hF, 32'h100, 32'h0);        wait_idle(50);
    set_req(1, 1'b1, 4'h0, 32'h100, 32'h12345678); wait_idle(50);
    set_req(0, 1'b0, 4'hF, 32'h100, 32'h0);        wait_idle(50);
    set_req(1, 1'b1, 4'b0101, 32'h100, 32'h11223344); wait_idle(50);
    set_req(1, 1'b0, 4'hF, 32'h100, 32'h0);        wait_idle(50);

    // Both cores stream writes: grants must alternate.
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NUM_CORES; i++)
        if (!req_r[i]) set_req(i, 1'b1, 4'hF, 32'h300 + 4 * i, 32'hA000_0000 + n);
      cycle_end();
    end
    wait_idle(50);

    // Sole requester is served twice, then a tie goes to the other core.
    set_req(0, 1'b1, 4'hF, 32'h400, 32'h1); wait_idle(50);
    set_req(0, 1'b1, 4'hF, 32'h404, 32'h2); wait_idle(50);
    set_req(0, 1'b1, 4'hF, 32'h408, 32'h3);
    set_req(1, 1'b1, 4'hF, 32'h40C, 32'h4); wait_idle(50);

    // Reset while a read waits on memory: the read is dropped silently.
    set_req(0, 1'b0, 4'hF, 32'h200, 32'h0);
    cycle_end();
    cycle_end();
    rst_n = 1'b0;
    req_r = '0;
    cycle_end();
    reset_outputs_zero();
    rst_n = 1'b1;
    set_req(1, 1'b0, 4'hF, 32'h100, 32'h0);
    wait_idle(50);

    // Random traffic with withdrawals and payload churn during reads.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        bit picked;
        picked = (cyc < model_free) && (i == model_owner);
        if (!req_r[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom);
        end else if (picked && !we_r[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            addr_r[i]  = rand_addr();
            wdata_r[i] = $urandom;
            mask_r[i]  = 4'($urandom_range(0, 15));
          end
        end else if (!picked && $urandom_range(0, 7) == 0) begin
          req_r[i] = 1'b0;
        end
      end
      cycle_end();
    end
    wait_idle(200);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
